modexp_win: RTL and testbench

Fixed-window (2^K-ary) modular exponentiation engine computing c = m^e mod n. It is the parametrised successor of the square-and-multiply exponentiator in the secure-boot datapath. Differences from that block:
- operands are latched at start;
- a precomputed table of m powers is used;
- the exponent length is runtime-programmable;
- an abort input is provided.

One shared `modmul` instance performs all squarings and multiplications.

---
 rtl/modexp_pkg.sv | 20 ++
 rtl/modexp_if.sv | 21 ++
 rtl/modexp_wtab.sv | 21 ++
 rtl/modmul.sv | 51 +++++
 rtl/modexp_win.sv | 186 ++++++++++++++++++
 tb/tb_modexp_win.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/modexp_pkg.sv
// Shared constants for the fixed-window modular exponentiator.
// FSM encoding, parameter defaults, window-width range and ops counter width.
package modexp_pkg;
  localparam int W_DEF   = 2048;
  localparam int K_DEF   = 4;
  localparam int EBW_DEF = 16;
  localparam int K_MIN   = 1;
  localparam int K_MAX   = 4;
  localparam int OPS_W   = 16;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_PRE_ISSUE = 3'd1;
  localparam state_t S_PRE_WAIT  = 3'd2;
  localparam state_t S_SQ_ISSUE  = 3'd3;
  localparam state_t S_SQ_WAIT   = 3'd4;
  localparam state_t S_MUL_ISSUE = 3'd5;
  localparam state_t S_MUL_WAIT  = 3'd6;
  localparam state_t S_FINISH    = 3'd7;
endpackage

// File: rtl/modexp_if.sv
// Command/result bundle of the modular exponentiator.
interface modexp_if import modexp_pkg::*; #(
  parameter int W   = W_DEF,
  parameter int EBW = EBW_DEF
) ();
  logic             start;
  logic             abort;
  logic [EBW-1:0]   ebits;
  logic [W-1:0]     m;
  logic [W-1:0]     e;
  logic [W-1:0]     n;
  logic             ready;
  logic             done;
  logic [W-1:0]     c;
  logic [OPS_W-1:0] ops;

  modport master (output start, abort, ebits, m, e, n,
                  input  ready, done, c, ops);
  modport slave  (input  start, abort, ebits, m, e, n,
                  output ready, done, c, ops);
endinterface

// File: rtl/modexp_wtab.sv
// 2^K x W power table: one synchronous write port, one combinational read port.
module modexp_wtab import modexp_pkg::*; #(
  parameter int W = W_DEF,
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         we,
  input  logic [K-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [K-1:0] raddr,
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [1 << K];

  // Table write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/modmul.sv
// Bit-serial interleaved modular multiplier: r = a*b mod n, W cycles per product.
// ready drops the cycle after an accepted start; requires a, b < n.
module modmul #(
  parameter int W = 2048
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         ready,
  output logic [W-1:0] r
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_r, b_r, n_r, r_r;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [W+1:0]  t0, t1, t2;

  // One step: r = 2r + a_msb*b, then fold back below n (2r+b < 3n).
  always_comb begin
    t0 = {1'b0, r_r, 1'b0} + (a_r[W-1] ? {2'b00, b_r} : '0);
    t1 = (t0 >= {2'b00, n_r}) ? t0 - {2'b00, n_r} : t0;
    t2 = (t1 >= {2'b00, n_r}) ? t1 - {2'b00, n_r} : t1;
  end

  // Operand latch and MSB-first iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      r_r <= W'(t2);
      a_r <= a_r << 1;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) busy <= 1'b0;
    end else if (start) begin
      a_r  <= a;
      b_r  <= b;
      n_r  <= n;
      r_r  <= '0;
      cnt  <= CW'(W);
      busy <= 1'b1;
    end
  end

  assign ready = ~busy;
  assign r     = r_r;
endmodule

// File: rtl/modexp_win.sv
// Fixed-window (2^K-ary) modular exponentiation c = m^e mod n over one shared modmul.
// Optional constant-time schedule: define MODEXP_CT_EN.
module modexp_win import modexp_pkg::*; #(
  parameter int W   = W_DEF,
  parameter int K   = K_DEF,
  parameter int EBW = EBW_DEF
) (
  input logic      clk,
  input logic      rst,
  modexp_if.slave  bus
);
  localparam int WW = $clog2(W + 1);
  localparam int NT = 1 << K;

  if (K < K_MIN || K > K_MAX) begin : g_bad_k
    $error("modexp_win: K out of range");
  end

  state_t           state;
  logic [W-1:0]     m_l, e_l, n_l, acc, c_r;
  logic [WW-1:0]    w, eb_c;
  logic [31:0]      nwin_c;
  logic [K-1:0]     j, raddr, dig;
  logic [2:0]       sq_cnt;
  logic             load_top, first_wait, done_r;
  logic [OPS_W-1:0] ops_r;
  logic [W-1:0]     ones, tab_q, tab_rd, src, mm_a, mm_b, mm_r;
  logic             mm_start, mm_ready, tab_we, is_pre, is_issue, got_res;

  // Clamp ebits to W and derive the window count for the operation being started.
  always_comb begin
    ones   = '1;
    eb_c   = (32'(bus.ebits) > W) ? WW'(W) : WW'(bus.ebits);
    nwin_c = (32'(eb_c) + K - 1) / K;
  end

  // Table addressing and modmul operand selection. Entries 0 and 1 are served
  // from the constant 1 and the latched base, so only 2..2^K-1 live in the table.
  // While load_top is set, acc is logically tab[top digit] (not yet copied).
  always_comb begin
    is_pre   = (state == S_PRE_ISSUE) || (state == S_PRE_WAIT);
    is_issue = (state == S_PRE_ISSUE) || (state == S_SQ_ISSUE) || (state == S_MUL_ISSUE);
    dig      = K'(e_l >> (32'(w) * K));
    raddr    = is_pre ? j - 1'b1 : dig;
    tab_rd   = (raddr == '0) ? W'(1) : ((raddr == K'(1)) ? m_l : tab_q);
    src      = load_top ? tab_rd : acc;
    mm_a     = acc;
    mm_b     = tab_rd;
    if (is_pre) begin
      mm_a = tab_rd;
      mm_b = m_l;
    end else if (state == S_SQ_ISSUE) begin
      mm_a = src;
      mm_b = src;
    end
    mm_start = is_issue && mm_ready && !bus.abort;
    got_res  = !first_wait && mm_ready && !bus.abort;
    tab_we   = (state == S_PRE_WAIT) && got_res;
  end

  modexp_wtab #(.W(W), .K(K)) u_tab (
    .clk   (clk),
    .we    (tab_we),
    .waddr (j),
    .wdata (mm_r),
    .raddr (raddr),
    .rdata (tab_q)
  );

  modmul #(.W(W)) u_mm (
    .clk   (clk),
    .rst   (rst),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .n     (n_l),
    .ready (mm_ready),
    .r     (mm_r)
  );

  // Control FSM, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      done_r     <= 1'b0;
      c_r        <= W'(1);
      ops_r      <= '0;
      load_top   <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state != S_IDLE && bus.abort) begin
        state    <= S_IDLE;
        load_top <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (bus.start && !done_r) begin
            m_l      <= bus.m;
            n_l      <= bus.n;
            e_l      <= bus.e & ~(ones << eb_c);
            ops_r    <= '0;
            acc      <= W'(1);
            j        <= K'(2);
            w        <= WW'(nwin_c - 1);
            sq_cnt   <= '0;
            load_top <= 1'b0;
            if (eb_c == '0) state <= S_FINISH;
            else if (K == 1) begin
`ifdef MODEXP_CT_EN
              state <= S_SQ_ISSUE;
`else
              load_top <= 1'b1;
              state    <= (nwin_c == 32'd1) ? S_FINISH : S_SQ_ISSUE;
`endif
            end else state <= S_PRE_ISSUE;
          end
          S_PRE_ISSUE, S_SQ_ISSUE, S_MUL_ISSUE: if (mm_ready) begin
            ops_r      <= ops_r + 1'b1;
            first_wait <= 1'b1;
            state      <= state + 3'd1;
            // The top-window load is folded into the first squaring's operands.
            if (state == S_SQ_ISSUE && load_top) begin
              load_top <= 1'b0;
              w        <= w - 1'b1;
            end
          end
          S_PRE_WAIT: if (first_wait) first_wait <= 1'b0;
          else if (mm_ready) begin
            if (j == K'(NT - 1)) begin
`ifdef MODEXP_CT_EN
              state <= S_SQ_ISSUE;
`else
              load_top <= 1'b1;
              state    <= (w == '0) ? S_FINISH : S_SQ_ISSUE;
`endif
            end else begin
              j     <= j + 1'b1;
              state <= S_PRE_ISSUE;
            end
          end
          S_SQ_WAIT: if (first_wait) first_wait <= 1'b0;
          else if (mm_ready) begin
            acc <= mm_r;
            if (sq_cnt < 3'(K - 1)) begin
              sq_cnt <= sq_cnt + 3'd1;
              state  <= S_SQ_ISSUE;
            end else begin
              sq_cnt <= '0;
`ifdef MODEXP_CT_EN
              state <= S_MUL_ISSUE;
`else
              if (dig != '0) state <= S_MUL_ISSUE;
              else if (w == '0) state <= S_FINISH;
              else begin
                w     <= w - 1'b1;
                state <= S_SQ_ISSUE;
              end
`endif
            end
          end
          S_MUL_WAIT: if (first_wait) first_wait <= 1'b0;
          else if (mm_ready) begin
            acc <= mm_r;
            if (w == '0) state <= S_FINISH;
            else begin
              w     <= w - 1'b1;
              state <= S_SQ_ISSUE;
            end
          end
          S_FINISH: begin
            c_r      <= src;
            done_r   <= 1'b1;
            load_top <= 1'b0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.ready = (state == S_IDLE) && !done_r;
  assign bus.done  = done_r;
  assign bus.c     = c_r;
  assign bus.ops   = ops_r;
endmodule

// File: tb/tb_modexp_win.sv
// Scoreboard bench for modexp_win (W=16, K=2) against a plain square-and-multiply model.
module tb_modexp_win;
  import modexp_pkg::*;
  localparam int W   = 16;
  localparam int K   = 2;
  localparam int EBW = 16;

  typedef struct { logic [W-1:0] c; logic [15:0] ops; } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] last_c;

  always #5 clk = ~clk;

  modexp_if #(.W(W), .EBW(EBW)) bus ();
  modexp_win #(.W(W), .K(K), .EBW(EBW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] m, e, n, input int eb);
    longint unsigned r = 1, b = m;
    int lim = (eb > W) ? W : eb;
    for (int i = 0; i < lim; i++) begin
      if (e[i]) r = (r * b) % n;
      b = (b * b) % n;
    end
    return W'(r % n);
  endfunction

  function automatic int ref_ops(input logic [W-1:0] e, input int eb);
    int lim = (eb > W) ? W : eb;
    int nwin, nz = 0;
    longint unsigned em = 0;
    if (lim == 0) return 0;
    nwin = (lim + K - 1) / K;
    for (int i = 0; i < lim; i++) if (e[i]) em = em | (64'd1 << i);
`ifdef MODEXP_CT_EN
    return (2 ** K - 2) + (K + 1) * nwin;
`else
    for (int i = 0; i < nwin - 1; i++)
      if (((em >> (i * K)) & ((64'd1 << K) - 1)) != 0) nz++;
    return (2 ** K - 2) + K * (nwin - 1) + nz;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got c=%0d with no operation outstanding", bus.c);
        end else begin
          x = sb.pop_front();
          check("result_c", 32'(bus.c), 32'(x.c));
          check("result_ops", 32'(bus.ops), 32'(x.ops));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  task automatic start_op(input logic [W-1:0] m, e, n, input int eb);
    wait_ready();
    bus.m = m; bus.e = e; bus.n = n; bus.ebits = EBW'(eb);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while ((sb.size() != 0 || bus.ready !== 1'b1) && cnt < 5000);
    if (cnt >= 5000) check("done_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_op(input logic [W-1:0] m, e, n, input int eb);
    exp_t x;
    x.c   = ref_pow(m, e, n, eb);
    x.ops = 16'(ref_ops(e, eb));
    sb.push_back(x);
    start_op(m, e, n, eb);
    wait_idle();
    last_c = x.c;
  endtask

  initial begin
    exp_t x;
    logic [W-1:0] rn, rm;
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.ebits = '0;
    bus.m = '0; bus.e = '0; bus.n = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_c", 32'(bus.c), 32'd1);
    check("rst_ops", 32'(bus.ops), 32'd0);
    rst = 1'b0;
    last_c = 1;
    @(negedge clk);

    // Worked example with hand-computed result.
    x.c = 16'd445;
`ifdef MODEXP_CT_EN
    x.ops = 16'd8;
`else
    x.ops = 16'd5;
`endif
    sb.push_back(x);
    start_op(16'd4, 16'd13, 16'd497, 4);
    wait_idle();
    last_c = 16'd445;

    // ebits=0: result 1, done in cycle 2, ready in cycle 3.
    x.c = 16'd1; x.ops = 16'd0;
    sb.push_back(x);
    start_op(16'd7, 16'hBEEF, 16'd101, 0);
    check("eb0_done_cyc1", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("eb0_done_cyc2", 32'(bus.done), 32'd1);
    check("eb0_ready_cyc2", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("eb0_ready_cyc3", 32'(bus.ready), 32'd1);
    last_c = 16'd1;

    run_op(16'd5, 16'd0, 16'd97, 16);
    run_op(16'd3, 16'hFFFF, 16'd65521, 16);
    run_op(16'd1234, 16'hA5C3, 16'd40001, 16);
    run_op(16'd1234, 16'hA5C3, 16'd40001, 20);
    run_op(16'd9, 16'h0003, 16'd1001, 3);

    // Abort three cycles after start: no done, c kept, one op issued so far.
    start_op(16'd11, 16'hF00D, 16'd30011, 16);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_c_hold", 32'(bus.c), 32'(last_c));
    check("abort_ops", 32'(bus.ops), 32'd1);
    run_op(16'd11, 16'hF00D, 16'd30011, 16);

    // start pulses while busy must not disturb the operation.
    x.c = ref_pow(16'd77, 16'h1357, 16'd60001, 16);
    x.ops = 16'(ref_ops(16'h1357, 16));
    sb.push_back(x);
    start_op(16'd77, 16'h1357, 16'd60001, 16);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      bus.m = 16'd2; bus.e = 16'd1; bus.n = 16'd3; bus.ebits = 16'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_idle();
    last_c = x.c;

    // Reset well inside the squaring phase.
    start_op(16'd21, 16'hFFFF, 16'd50001, 16);
    repeat (45) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_c", 32'(bus.c), 32'd1);
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_ops", 32'(bus.ops), 32'd0);
    rst = 1'b0;
    last_c = 1;
    run_op(16'd21, 16'hFFFF, 16'd50001, 16);

    for (int i = 0; i < 10; i++) begin
      rn = 16'($urandom_range(3, 65535)) | 16'd1;
      rm = 16'($urandom % 32'(rn));
      run_op(rm, 16'($urandom), rn, int'($urandom_range(0, 20)));
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
